// File: rtl/vdma_frame_addr_gen_if.sv
// Burst address channel between the VDMA frame address generator and the AXI address driver.
// The generator is the master; the address-channel driver is the slave.
interface vdma_frame_addr_gen_if #(
  parameter int unsigned ASIZE = 29
) ();
  logic             addr_valid;
  logic             addr_ready;
  logic [ASIZE-1:0] addr;
  logic             addr_tail;
  logic             addr_last;

  modport master (
    output addr_valid,
    output addr,
    output addr_tail,
    output addr_last,
    input  addr_ready
  );

  modport slave (
    input  addr_valid,
    input  addr,
    input  addr_tail,
    input  addr_last,
    output addr_ready
  );
endinterface

// File: rtl/vdma_frame_addr_gen.sv
// Per-frame burst address generator: rotates through FRAMES base buffers and walks each frame
// as lines of full bursts plus an optional tail burst, one address per valid/ready handshake.
module vdma_frame_addr_gen #(
  parameter int unsigned ASIZE          = 29,
  parameter int unsigned LSIZE          = 16,
  parameter int unsigned BSIZE          = 12,
  parameter int unsigned FRAMES         = 3,
  parameter int unsigned FISIZE         = 2,
  parameter int unsigned BURST_MAP_ADDR = 12800
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  base_load_i,
  input  logic [FISIZE-1:0]     base_index_i,
  input  logic [ASIZE-1:0]      base_addr_i,
  input  logic [ASIZE-1:0]      line_stride_i,
  input  logic [BSIZE-1:0]      bursts_per_line_i,
  input  logic [LSIZE-1:0]      lines_per_frame_i,
  input  logic                  tail_en_i,
  input  logic                  start_i,
  vdma_frame_addr_gen_if.master addr_if,
  output logic [FISIZE-1:0]     frame_index_o,
  output logic                  busy_o,
  output logic                  frame_done_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  state_e state_q, state_d;

  logic [ASIZE-1:0]  base_q [FRAMES];
  logic [FISIZE-1:0] frame_idx_q, frame_idx_d;

  // Configuration latched at start
  logic [ASIZE-1:0]  stride_q, stride_d;
  logic [BSIZE-1:0]  bursts_q, bursts_d;
  logic [LSIZE-1:0]  lines_q, lines_d;
  logic              tail_q, tail_d;

  // Walk state
  logic [ASIZE-1:0]  line_base_q, line_base_d;
  logic [ASIZE-1:0]  burst_addr_q, burst_addr_d;
  logic [BSIZE-1:0]  burst_cnt_q, burst_cnt_d;
  logic [LSIZE-1:0]  line_cnt_q, line_cnt_d;
  logic              cur_tail_q, cur_tail_d;

  logic              hs;
  logic              full_last;
  logic              line_last;
  logic              line_end;
  logic              frame_last;
  logic [BSIZE-1:0]  bursts_norm;
  logic [LSIZE-1:0]  lines_norm;
  logic [ASIZE-1:0]  next_line_base;

  assign hs = (state_q == StIssue) && addr_if.addr_ready;

  // Last full burst of the line (never true while the tail is presented)
  assign full_last  = !cur_tail_q &&
                      (((BSIZE+1)'(burst_cnt_q) + (BSIZE+1)'(1)) == (BSIZE+1)'(bursts_q));
  assign line_last  = ((LSIZE+1)'(line_cnt_q) + (LSIZE+1)'(1)) == (LSIZE+1)'(lines_q);
  assign line_end   = cur_tail_q || (full_last && !tail_q);
  assign frame_last = line_end && line_last;

  assign lines_norm  = (lines_per_frame_i == '0) ? LSIZE'(1) : lines_per_frame_i;
  assign bursts_norm = ((bursts_per_line_i == '0) && !tail_en_i) ? BSIZE'(1) : bursts_per_line_i;

  assign next_line_base = line_base_q + stride_q;

  // Base registers are writable in any state; an active frame keeps its latched copy.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FRAMES; i++) begin
        base_q[i] <= '0;
      end
    end else if (base_load_i) begin
      for (int unsigned i = 0; i < FRAMES; i++) begin
        if (base_index_i == FISIZE'(i)) begin
          base_q[i] <= base_addr_i;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StIssue;
      StIssue: if (hs && frame_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_if.addr_valid = (state_q == StIssue);
    addr_if.addr       = burst_addr_q;
    addr_if.addr_tail  = (state_q == StIssue) && cur_tail_q;
    addr_if.addr_last  = (state_q == StIssue) && frame_last;
    busy_o             = (state_q == StIssue);
    frame_done_o       = (state_q == StDone);
    frame_index_o      = frame_idx_q;
  end

  always_comb begin
    stride_d     = stride_q;
    bursts_d     = bursts_q;
    lines_d      = lines_q;
    tail_d       = tail_q;
    line_base_d  = line_base_q;
    burst_addr_d = burst_addr_q;
    burst_cnt_d  = burst_cnt_q;
    line_cnt_d   = line_cnt_q;
    cur_tail_d   = cur_tail_q;
    frame_idx_d  = frame_idx_q;

    if ((state_q == StIdle) && start_i) begin
      stride_d     = line_stride_i;
      bursts_d     = bursts_norm;
      lines_d      = lines_norm;
      tail_d       = tail_en_i;
      line_base_d  = base_q[frame_idx_q];
      burst_addr_d = base_q[frame_idx_q];
      burst_cnt_d  = '0;
      line_cnt_d   = '0;
      cur_tail_d   = (bursts_per_line_i == '0) && tail_en_i;
    end else if (hs && !frame_last) begin
      if (line_end) begin
        line_base_d  = next_line_base;
        burst_addr_d = next_line_base;
        burst_cnt_d  = '0;
        line_cnt_d   = line_cnt_q + LSIZE'(1);
        cur_tail_d   = (bursts_q == '0);
      end else begin
        // The tail address falls out of the same accumulator after the last full burst.
        burst_addr_d = burst_addr_q + ASIZE'(BURST_MAP_ADDR);
        if (full_last) begin
          cur_tail_d = 1'b1;
        end else begin
          burst_cnt_d = burst_cnt_q + BSIZE'(1);
        end
      end
    end

    if (state_q == StDone) begin
      frame_idx_d = (frame_idx_q == FISIZE'(FRAMES - 1)) ? '0 : frame_idx_q + FISIZE'(1);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      stride_q     <= '0;
      bursts_q     <= '0;
      lines_q      <= '0;
      tail_q       <= 1'b0;
      line_base_q  <= '0;
      burst_addr_q <= '0;
      burst_cnt_q  <= '0;
      line_cnt_q   <= '0;
      cur_tail_q   <= 1'b0;
      frame_idx_q  <= '0;
    end else begin
      stride_q     <= stride_d;
      bursts_q     <= bursts_d;
      lines_q      <= lines_d;
      tail_q       <= tail_d;
      line_base_q  <= line_base_d;
      burst_addr_q <= burst_addr_d;
      burst_cnt_q  <= burst_cnt_d;
      line_cnt_q   <= line_cnt_d;
      cur_tail_q   <= cur_tail_d;
      frame_idx_q  <= frame_idx_d;
    end
  end

endmodule

// File: tb/tb_vdma_frame_addr_gen.sv
// Directed bench for vdma_frame_addr_gen: a frame-level address-list model checked every cycle,
// plus literal expectations for each scenario.
module tb_vdma_frame_addr_gen;
  localparam int unsigned BMA = 12800;

  typedef struct packed {
    logic [28:0] a;
    logic        t;
    logic        l;
  } beat_t;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        base_load = 1'b0;
  logic [1:0]  base_index = '0;
  logic [28:0] base_addr = '0;
  logic [28:0] line_stride = '0;
  logic [11:0] bursts_per_line = '0;
  logic [15:0] lines_per_frame = '0;
  logic        tail_en = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  frame_index;
  logic        busy;
  logic        frame_done;

  vdma_frame_addr_gen_if #(.ASIZE(29)) aif ();

  vdma_frame_addr_gen dut (
    .clock             (clock),
    .rst_n             (rst_n),
    .base_load_i       (base_load),
    .base_index_i      (base_index),
    .base_addr_i       (base_addr),
    .line_stride_i     (line_stride),
    .bursts_per_line_i (bursts_per_line),
    .lines_per_frame_i (lines_per_frame),
    .tail_en_i         (tail_en),
    .start_i           (start),
    .addr_if           (aif),
    .frame_index_o     (frame_index),
    .busy_o            (busy),
    .frame_done_o      (frame_done)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          passes = 0;
  beat_t       exp_q[$];
  beat_t       log_q[$];
  logic [28:0] model_base [3];
  int          model_fidx = 0;
  bit          expect_done = 1'b0;
  bit          prev_stall = 1'b0;
  logic [28:0] prev_addr = '0;
  bit          exp_valid;
  beat_t       got;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
  endtask

  // Model: the frame is just the ordered list of burst addresses.
  task automatic push_frame(input logic [28:0] base, input int lines, input int bursts,
                            input logic [28:0] stride, input bit tail);
    int nl;
    int nb;
    logic [28:0] lb;
    beat_t e;
    nl = (lines == 0) ? 1 : lines;
    nb = (bursts == 0 && !tail) ? 1 : bursts;
    for (int j = 0; j < nl; j++) begin
      lb = base + stride * 29'(j);
      for (int k = 0; k < nb; k++) begin
        e.a = lb + 29'(k * BMA);
        e.t = 1'b0;
        e.l = (j == nl - 1) && (k == nb - 1) && !tail;
        exp_q.push_back(e);
      end
      if (tail) begin
        e.a = lb + 29'(nb * BMA);
        e.t = 1'b1;
        e.l = (j == nl - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  always @(negedge clock) begin
    if (rst_n) begin
      exp_valid = exp_q.size() > 0;
      check("addr_valid", 64'(aif.addr_valid), 64'(exp_valid));
      check("busy", 64'(busy), 64'(exp_valid));
      check("frame_done", 64'(frame_done), 64'(expect_done));
      check("frame_index", 64'(frame_index), 64'(model_fidx));
      if (expect_done) model_fidx = (model_fidx + 1) % 3;
      expect_done = 1'b0;
      if (aif.addr_valid && exp_valid) begin
        check("addr", 64'(aif.addr), 64'(exp_q[0].a));
        check("addr_tail", 64'(aif.addr_tail), 64'(exp_q[0].t));
        check("addr_last", 64'(aif.addr_last), 64'(exp_q[0].l));
        if (prev_stall) check("addr_hold", 64'(aif.addr), 64'(prev_addr));
        if (aif.addr_ready) begin
          got.a = aif.addr;
          got.t = aif.addr_tail;
          got.l = aif.addr_last;
          log_q.push_back(got);
          if (exp_q[0].l) expect_done = 1'b1;
          void'(exp_q.pop_front());
        end
      end
      prev_stall = aif.addr_valid && !aif.addr_ready;
      prev_addr  = aif.addr;
    end
  end

  task automatic load_base(input logic [1:0] idx, input logic [28:0] val);
    base_load  = 1'b1;
    base_index = idx;
    base_addr  = val;
    @(posedge clock);
    #1;
    base_load = 1'b0;
    if (idx < 3) model_base[idx] = val;
  endtask

  task automatic start_frame(input int lines, input int bursts, input logic [28:0] stride,
                             input bit tail);
    lines_per_frame = 16'(lines);
    bursts_per_line = 12'(bursts);
    line_stride     = stride;
    tail_en         = tail;
    log_q.delete();
    start = 1'b1;
    @(posedge clock);
    push_frame(model_base[model_fidx], lines, bursts, stride, tail);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    while ((exp_q.size() > 0 || expect_done) && n < 500) begin
      @(posedge clock);
      n++;
    end
    checks++;
    if (n < 500) passes++;
    else $display("FAIL frame_timeout: actual %0d cycles required < 500", n);
    @(posedge clock);
    @(posedge clock);
    #1;
  endtask

  task automatic wait_first();
    int n;
    n = 0;
    while (log_q.size() < 1 && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    checks++;
    if (n < 50) passes++;
    else $display("FAIL first_beat_timeout: actual %0d cycles required < 50", n);
  endtask

  task automatic check_beat(input string name, input int i, input logic [28:0] a,
                            input logic t, input logic l);
    if (log_q.size() > i) begin
      check({name, "_addr"}, 64'(log_q[i].a), 64'(a));
      check({name, "_tail"}, 64'(log_q[i].t), 64'(t));
      check({name, "_last"}, 64'(log_q[i].l), 64'(l));
    end else begin
      checks++;
      $display("FAIL %s_missing: actual %0d beats required > %0d", name, log_q.size(), i);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_valid"}, 64'(aif.addr_valid), 64'd0);
    check({name, "_addr"}, 64'(aif.addr), 64'd0);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_done"}, 64'(frame_done), 64'd0);
    check({name, "_fidx"}, 64'(frame_index), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) model_base[i] = '0;
    aif.addr_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clock);
    #1;

    load_base(2'd0, 29'h1000);
    load_base(2'd1, 29'h100000);
    load_base(2'd2, 29'h200000);
    load_base(2'd3, 29'h0555555);

    // Frame 0: two lines of two bursts
    start_frame(2, 2, 29'h8000, 1'b0);
    wait_frame();
    check("f0_beats", 64'(log_q.size()), 64'd4);
    check_beat("f0_b0", 0, 29'h1000, 1'b0, 1'b0);
    check_beat("f0_b1", 1, 29'h4200, 1'b0, 1'b0);
    check_beat("f0_b2", 2, 29'h9000, 1'b0, 1'b0);
    check_beat("f0_b3", 3, 29'hC200, 1'b0, 1'b1);
    check("f0_fidx", 64'(frame_index), 64'd1);

    // Frame 1: one burst plus tail
    start_frame(1, 1, 29'h0, 1'b1);
    wait_frame();
    check("f1_beats", 64'(log_q.size()), 64'd2);
    check_beat("f1_b0", 0, 29'h100000, 1'b0, 1'b0);
    check_beat("f1_b1", 1, 29'h103200, 1'b1, 1'b1);

    // Frame 2: stall the second burst, rewrite bases and pulse start while busy
    start_frame(2, 2, 29'h8000, 1'b0);
    wait_first();
    aif.addr_ready = 1'b0;
    load_base(2'd2, 29'h400000);
    load_base(2'd0, 29'h300000);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("stall_valid", 64'(aif.addr_valid), 64'd1);
    check("stall_addr", 64'(aif.addr), 64'h203200);
    aif.addr_ready = 1'b1;
    wait_frame();
    check("f2_beats", 64'(log_q.size()), 64'd4);
    check_beat("f2_b1", 1, 29'h203200, 1'b0, 1'b0);
    check_beat("f2_b3", 3, 29'h20B200, 1'b0, 1'b1);
    check("f2_fidx", 64'(frame_index), 64'd0);

    // Frame 3: rotation back to buffer 0 picks up the rewritten base
    start_frame(1, 1, 29'h0, 1'b0);
    wait_frame();
    check("f3_beats", 64'(log_q.size()), 64'd1);
    check_beat("f3_b0", 0, 29'h300000, 1'b0, 1'b1);

    // Frame 4: wrap past 2^29 with lines=0
    load_base(2'd1, 29'h1FFFF000);
    start_frame(0, 2, 29'h8000, 1'b0);
    wait_frame();
    check("f4_beats", 64'(log_q.size()), 64'd2);
    check_beat("f4_b0", 0, 29'h1FFFF000, 1'b0, 1'b0);
    check_beat("f4_b1", 1, 29'h00002200, 1'b0, 1'b1);

    // Frame 5: bursts=0 without tail gives one burst per line
    start_frame(2, 0, 29'h10, 1'b0);
    wait_frame();
    check("f5_beats", 64'(log_q.size()), 64'd2);
    check_beat("f5_b0", 0, 29'h400000, 1'b0, 1'b0);
    check_beat("f5_b1", 1, 29'h400010, 1'b0, 1'b1);

    // Frame 6: tail-only lines
    start_frame(2, 0, 29'h10, 1'b1);
    wait_frame();
    check("f6_beats", 64'(log_q.size()), 64'd2);
    check_beat("f6_b0", 0, 29'h300000, 1'b1, 1'b0);
    check_beat("f6_b1", 1, 29'h300010, 1'b1, 1'b1);

    // Reset after the first of four bursts
    start_frame(2, 2, 29'h8000, 1'b0);
    wait_first();
    rst_n = 1'b0;
    exp_q.delete();
    expect_done = 1'b0;
    prev_stall  = 1'b0;
    model_fidx  = 0;
    for (int i = 0; i < 3; i++) model_base[i] = '0;
    #1;
    check_idle_outputs("midreset");
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    @(posedge clock);
    #1;
    start_frame(1, 1, 29'h0, 1'b0);
    wait_frame();
    check("f7_beats", 64'(log_q.size()), 64'd1);
    check_beat("f7_b0", 0, 29'h0, 1'b0, 1'b1);
    check("f7_fidx", 64'(frame_index), 64'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
